// File: rtl/enc16to4_arb.sv
// Sticky 16-line request capture encoded one index at a time onto a 4-bit code.
// Request-to-code latency 2 edges; a stalled code is held, and new requests still collect into pending.
module enc16to4_arb #(
    parameter bit RR = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] req,
    output logic [3:0]  out_code,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        out_multi,
    output logic [15:0] pending
);

    logic [15:0] r_pending;
    logic [3:0]  r_code;
    logic        r_valid;
    logic        r_multi;
    logic [3:0]  r_ptr;

    logic        w_acc;
    logic        w_load;
    logic [15:0] w_acc_oh;
    logic [15:0] w_cand;
    logic [3:0]  w_base;
    logic [3:0]  w_sel;
    logic        w_found;
    logic        w_multi;

    assign w_acc  = r_valid & out_ready;
    assign w_load = ~r_valid | w_acc;

    always_comb begin
        w_acc_oh = '0;
        if (w_acc) begin
            w_acc_oh[r_code] = 1'b1;
        end
    end

    // The index being accepted is masked so it can never be re-presented back-to-back.
    assign w_cand  = r_pending & ~w_acc_oh;
    assign w_multi = |(w_cand & (w_cand - 16'd1));
    assign w_base  = RR ? (r_ptr + 4'd1) : 4'd0;

    always_comb begin
        w_sel   = 4'd0;
        w_found = 1'b0;
        for (int i = 0; i < 16; i++) begin
            if (!w_found && w_cand[w_base + 4'(i)]) begin
                w_sel   = w_base + 4'(i);
                w_found = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pending <= '0;
            r_code    <= 4'd0;
            r_valid   <= 1'b0;
            r_multi   <= 1'b0;
            r_ptr     <= 4'hF;
        end else begin
            r_pending <= w_cand | req;
            if (w_acc) begin
                r_ptr <= r_code;
            end
            if (w_load) begin
                if (w_found) begin
                    r_valid <= 1'b1;
                    r_code  <= w_sel;
                    r_multi <= w_multi;
                end else begin
                    r_valid <= 1'b0;
                end
            end
        end
    end

    assign out_code  = r_code;
    assign out_valid = r_valid;
    assign out_multi = r_multi;
    assign pending   = r_pending;

endmodule

// File: tb/tb_enc16to4_arb.sv
// Bench for enc16to4_arb: fixed-priority and round-robin instances run side by side
// against an index-search reference model, plus literal scenario expectations.
module tb_enc16to4_arb;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] req = 16'h0;
    logic        out_ready = 1'b0;

    logic [3:0]  code0, code1;
    logic        valid0, valid1, multi0, multi1;
    logic [15:0] pend0, pend1;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    enc16to4_arb #(.RR(1'b0)) u_fixed (
        .clk(clk), .rst(rst), .req(req),
        .out_code(code0), .out_valid(valid0), .out_ready(out_ready),
        .out_multi(multi0), .pending(pend0)
    );

    enc16to4_arb #(.RR(1'b1)) u_rr (
        .clk(clk), .rst(rst), .req(req),
        .out_code(code1), .out_valid(valid1), .out_ready(out_ready),
        .out_multi(multi1), .pending(pend1)
    );

    // Reference model, one slot per instance (slot 1 is round-robin).
    logic [15:0] m_pend  [2] = '{16'h0, 16'h0};
    logic [3:0]  m_code  [2] = '{4'd0, 4'd0};
    logic        m_valid [2] = '{1'b0, 1'b0};
    logic        m_multi [2] = '{1'b0, 1'b0};
    int          m_ptr   [2] = '{15, 15};

    function automatic void chk(input string name, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h expected=%h at %0t", name, got, exp, $time);
        end
    endfunction

    task automatic model_step(input int r);
        logic [15:0] cand;
        bit          acc;
        int          sel;
        int          idx;
        acc  = m_valid[r] && out_ready;
        cand = m_pend[r];
        if (acc) cand[m_code[r]] = 1'b0;
        sel = -1;
        for (int k = 0; k < 16; k++) begin
            idx = (r == 1) ? (m_ptr[r] + 1 + k) % 16 : k;
            if (sel < 0 && cand[idx]) sel = idx;
        end
        if (acc) m_ptr[r] = m_code[r];
        if (!m_valid[r] || acc) begin
            if (sel >= 0) begin
                m_valid[r] = 1'b1;
                m_code[r]  = 4'(sel);
                m_multi[r] = ($countones(cand) > 1);
            end else begin
                m_valid[r] = 1'b0;
            end
        end
        m_pend[r] = cand | req;
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < 2; r++) begin
                m_pend[r] = 16'h0; m_code[r] = 4'd0; m_valid[r] = 1'b0;
                m_multi[r] = 1'b0; m_ptr[r] = 15;
            end
        end else begin
            for (int r = 0; r < 2; r++) model_step(r);
        end
    end

    always @(negedge clk) begin
        chk("fixed_valid", 16'(valid0), 16'(m_valid[0]));
        chk("fixed_code",  16'(code0),  16'(m_code[0]));
        chk("fixed_multi", 16'(multi0), 16'(m_multi[0]));
        chk("fixed_pend",  pend0,       m_pend[0]);
        chk("rr_valid",    16'(valid1), 16'(m_valid[1]));
        chk("rr_code",     16'(code1),  16'(m_code[1]));
        chk("rr_multi",    16'(multi1), 16'(m_multi[1]));
        chk("rr_pend",     pend1,       m_pend[1]);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Asserts reset between edges and checks the outputs clear before any edge.
    task automatic pulse_reset();
        #2 rst = 1'b1;
        #1;
        chk("rst_pend0",  pend0, 16'h0);
        chk("rst_valid0", 16'(valid0), 16'h0);
        chk("rst_code0",  16'(code0), 16'h0);
        chk("rst_multi0", 16'(multi0), 16'h0);
        chk("rst_pend1",  pend1, 16'h0);
        chk("rst_valid1", 16'(valid1), 16'h0);
        #3 rst = 1'b0;
        tick();
    endtask

    int exp_fixed [6] = '{2, 5, 2, 5, 2, 5};
    int exp_rr    [6] = '{2, 5, 9, 2, 5, 9};
    int burst_c   [4] = '{0, 5, 10, 15};
    int burst_m   [4] = '{1, 1, 1, 0};

    initial begin
        tick();
        tick();
        rst = 1'b0;
        tick();

        // Reset in the middle of a stalled transfer.
        out_ready = 1'b0;
        req = 16'hFFFF;
        repeat (3) tick();
        req = 16'h0;
        pulse_reset();
        repeat (3) tick();
        chk("post_rst_valid0", 16'(valid0), 16'h0);
        chk("post_rst_valid1", 16'(valid1), 16'h0);

        // Single pulse.
        out_ready = 1'b1;
        req = 16'h0020;
        tick();
        req = 16'h0;
        chk("single_early_valid", 16'(valid0), 16'h0);
        tick();
        chk("single_valid0", 16'(valid0), 16'h1);
        chk("single_code0",  16'(code0),  16'h5);
        chk("single_multi0", 16'(multi0), 16'h0);
        chk("single_code1",  16'(code1),  16'h5);
        tick();
        chk("single_done_valid", 16'(valid0), 16'h0);
        chk("single_done_pend",  pend0, 16'h0);

        // Burst through the fixed-priority instance.
        req = 16'h8421;
        tick();
        req = 16'h0;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("burst_valid", 16'(valid0), 16'h1);
            chk("burst_code",  16'(code0),  16'(burst_c[i]));
            chk("burst_multi", 16'(multi0), 16'(burst_m[i]));
        end
        tick();
        chk("burst_end_valid", 16'(valid0), 16'h0);

        // Backpressure with a request arriving mid-stall.
        out_ready = 1'b0;
        req = 16'h0001;
        tick();
        req = 16'h0;
        tick();
        chk("stall_valid", 16'(valid0), 16'h1);
        chk("stall_code",  16'(code0),  16'h0);
        for (int i = 0; i < 4; i++) begin
            if (i == 1) req = 16'h0008;
            tick();
            req = 16'h0;
            chk("stall_hold_valid", 16'(valid0), 16'h1);
            chk("stall_hold_code",  16'(code0),  16'h0);
        end
        chk("stall_pend", pend0, 16'h0009);
        out_ready = 1'b1;
        tick();
        chk("stall_next_code",  16'(code0),  16'h3);
        chk("stall_next_valid", 16'(valid0), 16'h1);
        tick();
        chk("stall_drain_valid", 16'(valid0), 16'h0);
        chk("stall_drain_pend",  pend0, 16'h0);

        // Held requests from a known pointer.
        pulse_reset();
        out_ready = 1'b1;
        req = 16'h0224;
        tick();
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("held_fixed_code", 16'(code0), 16'(exp_fixed[i]));
            chk("held_rr_code",    16'(code1), 16'(exp_rr[i]));
            chk("held_rr_valid",   16'(valid1), 16'h1);
        end
        req = 16'h0;
        repeat (10) tick();

        // Re-request of the index being accepted.
        req = 16'h0080;
        tick();
        req = 16'h0;
        tick();
        chk("rereq_code",  16'(code0),  16'h7);
        chk("rereq_valid", 16'(valid0), 16'h1);
        req = 16'h0080;
        tick();
        req = 16'h0;
        chk("rereq_pend",      pend0, 16'h0080);
        chk("rereq_gap_valid", 16'(valid0), 16'h0);
        tick();
        chk("rereq_again_valid", 16'(valid0), 16'h1);
        chk("rereq_again_code",  16'(code0),  16'h7);
        tick();
        chk("rereq_done_valid", 16'(valid0), 16'h0);

        // Randomized traffic checked by the model on every cycle.
        for (int n = 0; n < 3000; n++) begin
            req = ($urandom_range(0, 2) == 0) ? 16'($urandom & $urandom) : 16'h0;
            out_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 499) == 0) begin
                pulse_reset();
            end else begin
                tick();
            end
        end
        req = 16'h0;
        out_ready = 1'b1;
        repeat (40) tick();
        chk("final_valid0", 16'(valid0), 16'h0);
        chk("final_pend1",  pend1, 16'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
